// File: rtl/prim_reg_responder.sv
// prim_reg_responder
// Bridges a valid/ready register bus to a bank of software-accessible
// subregisters. Each accepted request is decoded to a word index. A valid
// write raises a one-cycle write strobe carrying byte-merged write data. A
// valid read raises a one-cycle read strobe and returns the sampled register
// value. Every transaction produces exactly one response with an error flag.
//
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   req_valid/ready    request handshake
//   req_write          1 = write, 0 = read
//   req_addr           byte address (word aligned, index = req_addr[AW-1:2])
//   req_wdata, req_be  write data and byte enables
//   rsp_valid/ready    response handshake
//   rsp_rdata          read data (0 for writes and errors)
//   rsp_error          response carries an error
//   reg_we, reg_re     one-hot, one-cycle write / read strobes
//   reg_wd             merged write data shared by all subregisters
//   reg_qs             flattened current subregister values, reg i at [i*DW +: DW]
module prim_reg_responder #(
    parameter int DW    = 32,
    parameter int NREGS = 8,
    parameter int AW    = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [AW-1:0]         req_addr,
    input  logic [DW-1:0]         req_wdata,
    input  logic [DW/8-1:0]       req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  rsp_error,
    output logic [NREGS-1:0]      reg_we,
    output logic [NREGS-1:0]      reg_re,
    output logic [DW-1:0]         reg_wd,
    input  logic [NREGS*DW-1:0]   reg_qs
);

    localparam int BW = DW / 8;
    localparam int IW = AW - 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    state_e             state_r;
    logic [NREGS-1:0]   reg_we_r;
    logic [NREGS-1:0]   reg_re_r;
    logic [DW-1:0]      reg_wd_r;
    logic [DW-1:0]      rsp_rdata_r;
    logic               rsp_error_r;

    logic               accept_s;
    logic [IW-1:0]      idx_s;
    logic               addr_err_s;
    logic               be_err_s;
    logic               err_s;
    logic [NREGS-1:0]   onehot_s;
    logic [DW-1:0]      qs_sel_s;
    logic [DW-1:0]      merged_s;

    // Per byte: take the new write byte where enabled, else keep the current value.
    function automatic logic [DW-1:0] merge_bytes(
        input logic [DW-1:0] wdata,
        input logic [DW-1:0] cur,
        input logic [BW-1:0] be
    );
        logic [DW-1:0] res;
        res = {DW{1'b0}};
        for (int b = 0; b < BW; b++) begin
            res[b*8 +: 8] = be[b] ? wdata[b*8 +: 8] : cur[b*8 +: 8];
        end
        return res;
    endfunction

    // In RESP the bus may accept the next request in the same cycle the
    // current response is consumed, which sustains one transaction per cycle.
    assign req_ready = (state_r == ST_IDLE) || rsp_ready;
    assign accept_s  = req_valid && req_ready;

    // Address / byte-enable decode and readback selection for the request.
    always_comb begin
        idx_s      = req_addr[AW-1:2];
        addr_err_s = (req_addr[1:0] != 2'b00) || (int'(idx_s) >= NREGS);
        be_err_s   = req_write && (req_be == {BW{1'b0}});
        err_s      = addr_err_s || be_err_s;
        onehot_s   = {NREGS{1'b0}};
        qs_sel_s   = {DW{1'b0}};
        // AND-OR mux: an out-of-range index selects nothing and yields zero.
        for (int i = 0; i < NREGS; i++) begin
            onehot_s[i] = (idx_s == i[IW-1:0]);
            qs_sel_s    = qs_sel_s | (reg_qs[i*DW +: DW] & {DW{onehot_s[i]}});
        end
        merged_s = merge_bytes(req_wdata, qs_sel_s, req_be);
    end

    // Response FSM with registered strobes, write data and response fields.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            reg_we_r    <= {NREGS{1'b0}};
            reg_re_r    <= {NREGS{1'b0}};
            reg_wd_r    <= {DW{1'b0}};
            rsp_rdata_r <= {DW{1'b0}};
            rsp_error_r <= 1'b0;
        end else begin
            // Strobes are pulses: they only fire in the cycle after an accept,
            // so back-pressure on the response never repeats them.
            reg_we_r <= {NREGS{1'b0}};
            reg_re_r <= {NREGS{1'b0}};
            case (state_r)
                ST_IDLE, ST_RESP: begin
                    if (accept_s) begin
                        state_r <= ST_RESP;
                        if (err_s) begin
                            // reg_wd intentionally keeps its previous value.
                            rsp_rdata_r <= {DW{1'b0}};
                            rsp_error_r <= 1'b1;
                        end else if (req_write) begin
                            reg_we_r    <= onehot_s;
                            reg_wd_r    <= merged_s;
                            rsp_rdata_r <= {DW{1'b0}};
                            rsp_error_r <= 1'b0;
                        end else begin
                            reg_re_r    <= onehot_s;
                            rsp_rdata_r <= qs_sel_s;
                            rsp_error_r <= 1'b0;
                        end
                    end else if ((state_r == ST_RESP) && rsp_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = (state_r == ST_RESP);
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_error = rsp_error_r;
    assign reg_we    = reg_we_r;
    assign reg_re    = reg_re_r;
    assign reg_wd    = reg_wd_r;

endmodule

// File: tb/tb_prim_reg_responder.sv
// Self-checking bench for prim_reg_responder. A negedge monitor models the
// expected response of every accepted request into a queue and compares when
// the response handshake happens. It also checks strobes and write data one
// cycle after each accept. Directed checks cover the spec scenarios.
module tb_prim_reg_responder;

    localparam int DW    = 32;
    localparam int NREGS = 8;
    localparam int AW    = 8;
    localparam int BW    = DW / 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [AW-1:0]        req_addr;
    logic [DW-1:0]        req_wdata;
    logic [BW-1:0]        req_be;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DW-1:0]        rsp_rdata;
    logic                 rsp_error;
    logic [NREGS-1:0]     reg_we;
    logic [NREGS-1:0]     reg_re;
    logic [DW-1:0]        reg_wd;
    logic [NREGS*DW-1:0]  reg_qs;

    logic [DW-1:0]        qs [NREGS];

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    rsp_t                 rsp_q[$];
    logic [NREGS-1:0]     exp_we;
    logic [NREGS-1:0]     exp_re;
    logic [DW-1:0]        exp_wd;

    int n_tests = 0;
    int n_fail  = 0;

    prim_reg_responder #(.DW(DW), .NREGS(NREGS), .AW(AW)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_wd    (reg_wd),
        .reg_qs    (reg_qs)
    );

    always #5 clk = ~clk;

    always_comb begin
        reg_qs = '0;
        for (int i = 0; i < NREGS; i++) begin
            reg_qs[i*DW +: DW] = qs[i];
        end
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard monitor: compares last cycle's expectations, pops responses
    // on handshake, pushes the modelled response of a request accepted now.
    always @(negedge clk) begin : monitor
        automatic logic             model_ready;
        automatic logic [AW-3:0]    idx;
        automatic logic             err;
        automatic rsp_t             e;
        automatic logic [DW-1:0]    m;
        automatic logic [NREGS-1:0] nwe;
        automatic logic [NREGS-1:0] nre;
        if (rst) begin
            rsp_q.delete();
            exp_we <= '0;
            exp_re <= '0;
        end else begin
            model_ready = (rsp_q.size() == 0) || rsp_ready;
            check_val("req_ready", req_ready, model_ready);
            check_val("rsp_valid", rsp_valid, rsp_q.size() != 0);
            check_val("reg_we", reg_we, exp_we);
            check_val("reg_re", reg_re, exp_re);
            if (exp_we != '0) check_val("reg_wd", reg_wd, exp_wd);
            if (rsp_valid && rsp_ready && rsp_q.size() != 0) begin
                e = rsp_q.pop_front();
                check_val("rsp_rdata", rsp_rdata, e.rdata);
                check_val("rsp_error", rsp_error, e.err);
            end
            nwe = '0;
            nre = '0;
            if (req_valid && model_ready) begin
                idx = req_addr[AW-1:2];
                err = (req_addr[1:0] != 2'b00) || (int'(idx) >= NREGS) ||
                      (req_write && (req_be == '0));
                if (err) begin
                    e.rdata = '0;
                    e.err   = 1'b1;
                end else if (req_write) begin
                    for (int b = 0; b < BW; b++) begin
                        m[b*8 +: 8] = req_be[b] ? req_wdata[b*8 +: 8] : qs[idx][b*8 +: 8];
                    end
                    nwe[idx] = 1'b1;
                    exp_wd  <= m;
                    e.rdata  = '0;
                    e.err    = 1'b0;
                end else begin
                    nre[idx] = 1'b1;
                    e.rdata  = qs[idx];
                    e.err    = 1'b0;
                end
                rsp_q.push_back(e);
            end
            exp_we <= nwe;
            exp_re <= nre;
        end
    end

    // Present a request (called just after a posedge), wait for acceptance,
    // and return #1 after the accepting edge with req_valid dropped.
    task automatic do_req(input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic [BW-1:0] be);
        int waited;
        waited    = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!req_ready) check_val("req_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREGS; i++) qs[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_rsp_valid", rsp_valid, 1'b0);
        check_val("rst_req_ready", req_ready, 1'b1);
        check_val("rst_reg_we", reg_we, 8'h00);
        check_val("rst_reg_re", reg_re, 8'h00);
        check_val("rst_reg_wd", reg_wd, 32'h0);
        check_val("rst_rsp_rdata", rsp_rdata, 32'h0);
        check_val("rst_rsp_error", rsp_error, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full write then read of register 2.
        do_req(1'b1, 8'h08, 32'hDEADBEEF, 4'hF);
        check_val("wr_reg_we", reg_we, 8'b0000_0100);
        check_val("wr_reg_wd", reg_wd, 32'hDEADBEEF);
        check_val("wr_rsp_valid", rsp_valid, 1'b1);
        check_val("wr_rsp_error", rsp_error, 1'b0);
        qs[2] = 32'hDEADBEEF;
        do_req(1'b0, 8'h08, 32'h0, 4'h0);
        check_val("rd_rdata", rsp_rdata, 32'hDEADBEEF);
        check_val("rd_reg_re", reg_re, 8'b0000_0100);
        @(posedge clk);
        #1;
        check_val("rd_re_single", reg_re, 8'h00);

        // Partial-write merge.
        qs[1] = 32'h11223344;
        do_req(1'b1, 8'h04, 32'hAABBCCDD, 4'b0101);
        check_val("merge_wd", reg_wd, 32'h11BB33DD);
        check_val("merge_we", reg_we, 8'b0000_0010);
        @(posedge clk);
        #1;
        check_val("merge_we_single", reg_we, 8'h00);

        // Error cases.
        do_req(1'b0, 8'h20, 32'h0, 4'h0);
        check_val("err_idx_error", rsp_error, 1'b1);
        check_val("err_idx_rdata", rsp_rdata, 32'h0);
        check_val("err_idx_strobe", reg_we | reg_re, 8'h00);
        do_req(1'b1, 8'h05, 32'hCAFEF00D, 4'hF);
        check_val("err_align_error", rsp_error, 1'b1);
        check_val("err_align_strobe", reg_we | reg_re, 8'h00);
        do_req(1'b1, 8'h00, 32'h12345678, 4'h0);
        check_val("err_be_error", rsp_error, 1'b1);
        check_val("err_be_strobe", reg_we | reg_re, 8'h00);
        check_val("err_wd_hold", reg_wd, 32'h11BB33DD);
        @(posedge clk);
        #1;

        // Back-pressure on a read of register 3, then a queued write.
        qs[3] = 32'hC0FFEE03;
        rsp_ready = 1'b0;
        do_req(1'b0, 8'h0C, 32'h0, 4'h0);
        check_val("bp_reg_re", reg_re, 8'b0000_1000);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h00;
        req_wdata = 32'h5A5A5A5A;
        req_be    = 4'hF;
        for (int k = 0; k < 5; k++) begin
            check_val("bp_req_ready", req_ready, 1'b0);
            check_val("bp_rsp_valid", rsp_valid, 1'b1);
            check_val("bp_rsp_rdata", rsp_rdata, 32'hC0FFEE03);
            check_val("bp_rsp_error", rsp_error, 1'b0);
            if (k > 0) check_val("bp_re_once", reg_re, 8'h00);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_val("bp_wr_rsp_valid", rsp_valid, 1'b1);
        check_val("bp_wr_reg_we", reg_we, 8'b0000_0001);
        check_val("bp_wr_rdata", rsp_rdata, 32'h0);
        @(posedge clk);
        #1;
        check_val("bp_drained", rsp_valid, 1'b0);

        // Streaming: 8 back-to-back reads with rsp_ready held high.
        for (int i = 0; i < NREGS; i++) qs[i] = 32'h1000_0000 + 32'h0101_0101 * i;
        for (int i = 0; i < NREGS; i++) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = 8'(4 * i);
            @(posedge clk);
            #1;
            check_val("stream_valid", rsp_valid, 1'b1);
            check_val("stream_rdata", rsp_rdata, 32'h1000_0000 + 32'h0101_0101 * i);
        end
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check_val("stream_done", rsp_valid, 1'b0);

        // Reset while a read response is pending.
        qs[4] = 32'h4444_0004;
        rsp_ready = 1'b0;
        do_req(1'b0, 8'h10, 32'h0, 4'h0);
        check_val("mid_reg_re", reg_re, 8'b0001_0000);
        #1;
        rst = 1'b1;
        #1;
        check_val("mid_rsp_valid", rsp_valid, 1'b0);
        check_val("mid_reg_re_clr", reg_re, 8'h00);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("post_rst_ready", req_ready, 1'b1);
        check_val("post_rst_valid", rsp_valid, 1'b0);
        rsp_ready = 1'b1;
        do_req(1'b0, 8'h10, 32'h0, 4'h0);
        check_val("post_rst_rdata", rsp_rdata, 32'h4444_0004);
        check_val("post_rst_rsp", rsp_valid, 1'b1);
        @(posedge clk);
        #1;
        check_val("post_rst_single", rsp_valid, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check_val("rsp_q_empty", rsp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prim_reg_responder.md
Name: prim_reg_responder

Overview:
- Register-bus responder sitting between a simple valid/ready register bus and a bank of software-accessible subregisters.
- Decodes word addresses and issues one-cycle write strobes with shared write data to the subregister bank.
- Byte-masked writes are merged against the current subregister value.
- Read data comes from the bank's flattened readback bus, and each transaction gets exactly one response with an error flag.

Parameters:
- DW, 32, data width in bits; must be a multiple of 8.
- NREGS, 8, number of subregisters, indexed 0..NREGS-1 at byte address 4*i.
- AW, 8, address width in bits; 4*NREGS must fit in AW bits.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request valid.
- req_ready  output  1  request accepted when req_valid & req_ready.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  AW  byte address.
- req_wdata  input  DW  write data.
- req_be  input  DW/8  byte enables; write only.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  output  DW  read data; 0 for writes and errors.
- rsp_error  output  1  response carries an error.
- reg_we  output  NREGS  one-hot write strobe, one cycle.
- reg_re  output  NREGS  one-hot read strobe, one cycle; used by read-to-clear registers.
- reg_wd  output  DW  merged write data, shared by all registers.
- reg_qs  input  NREGS*DW  current register values; register i occupies bits [i*DW +: DW].

Behaviour:
- Reset: the asynchronous, active-high rst_i forces:
  - FSM to IDLE;
  - rsp_valid=0, rsp_error=0, rsp_rdata=0;
  - reg_we=0, reg_re=0, reg_wd=0.
  - req_ready follows the FSM and is therefore 1 while in IDLE.
- FSM states:
  - IDLE: req_ready=1, rsp_valid=0.
  - RESP: rsp_valid=1; all response fields held stable until the handshake.
- IDLE -> RESP on request accept (req_valid & req_ready).
- RESP -> IDLE on rsp_valid & rsp_ready, unless a new request is accepted in the same cycle.
- In RESP, req_ready = rsp_ready, so a new request may be accepted in the same cycle as the response handshake; the FSM then stays in RESP.
- Sustained throughput: one transaction per cycle when rsp_ready is held high.
- Decode on accept, with idx = req_addr[AW-1:2]:
  - Error if req_addr[1:0] != 0 or idx >= NREGS.
  - Error if a write has req_be == 0.
  - Otherwise the access is valid.
- Valid write, on the cycle after accept:
  - reg_we[idx]=1;
  - reg_wd = per byte b: req_be[b] ? req_wdata byte b : reg_qs[idx] byte b, with reg_qs sampled in the accept cycle.
  - rsp_valid=1, rsp_rdata=0, rsp_error=0.
- Valid read, on the cycle after accept:
  - reg_re[idx]=1;
  - rsp_rdata = reg_qs[idx], sampled in the accept cycle;
  - rsp_error=0.
- Error access:
  - No reg_we or reg_re strobe.
  - rsp_error=1, rsp_rdata=0.
  - reg_wd holds its previous value.
- Strobes:
  - reg_we and reg_re are registered and high for exactly one cycle per accepted transaction, independent of rsp_ready back-pressure.
  - At most one bit of reg_we|reg_re is set in any cycle.
- Latency: accept to rsp_valid is 1 cycle. The response stalls indefinitely while rsp_ready=0, with no further strobes.
- Request inputs are ignored whenever req_ready=0.
- Reset mid-transaction (rst_i asserted in RESP or during a strobe cycle):
  - pending response discarded;
  - strobes deasserted immediately;
  - after reset the block returns to IDLE and produces no response for the lost transaction.

Test Plan:
- Full write then read (reset, NREGS=8): write addr 0x08, wdata 0xDEADBEEF, be 0xF with reg_qs[2] = 0 -> next cycle reg_we = 8'b0000_0100, reg_wd = 0xDEADBEEF, rsp_valid=1, rsp_error=0. Then, with reg_qs[2] modelled as 0xDEADBEEF, read 0x08 -> rsp_rdata = 0xDEADBEEF, reg_re = 8'b0000_0100 for one cycle.
- Partial-write merge: reg_qs[1] = 0x11223344, write addr 0x04, wdata 0xAABBCCDD, be 0b0101 -> reg_wd = 0x11BB33DD, single-cycle reg_we[1].
- Errors:
  - read addr 0x20 (idx 8) -> rsp_error=1, rsp_rdata=0, no strobes;
  - write addr 0x05 -> rsp_error=1, no strobes;
  - write be=0 -> rsp_error=1, no strobes.
- Back-pressure: rsp_ready=0 for 5 cycles after a read of addr 0x0C -> req_ready=0 and rsp fields stable all 5 cycles; reg_re pulses once only. Then rsp_ready=1 together with a queued write to 0x00 -> that write is accepted in the same cycle and its response appears the next cycle.
- Streaming: rsp_ready held 1 and 8 back-to-back reads of 0x00..0x1C -> 8 responses on 8 consecutive cycles, each rsp_rdata equal to the corresponding reg_qs slice.
- Reset mid-transaction: assert rst_i while in RESP with a pending read -> rsp_valid drops immediately and req_ready=1 after reset release. The next read returns a correct, single response.
